pattern_sequencer: RTL

Programmable successor to the fixed 4-in/10-out note decoder used in the music box.
- Holds a writable lookup table of 2^IN_W entries, each OUT_W bits wide.
- Direct mode: decodes a selected index exactly as the fixed decoder did, but the result is registered.
- Sequence mode: steps through entries 0..last_step at a programmable tempo, one-shot or looping, so it can drive the note/LED outputs of the box.

---
 rtl/music_box_pkg.sv | 14 +
 rtl/pattern_table.sv | 32 +++
 rtl/pattern_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/music_box_pkg.sv
// Shared types and default widths for the music box pattern sequencer.
package music_box_pkg;

  localparam int IN_W_DEF  = 4;
  localparam int OUT_W_DEF = 10;
  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_table.sv
// 2^IN_W x OUT_W register file: async clear, one synchronous write port and
// one combinational read port (a same-cycle read of the written address sees the old value).
module pattern_table #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IN_W-1:0]  waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [IN_W-1:0]  raddr,
  output logic [OUT_W-1:0] rdata
);

  localparam int DEPTH = 2 ** IN_W;

  logic [OUT_W-1:0] mem [DEPTH];

  // NOTE: this table is small flop storage that must read back as zero after
  // reset, so every entry is cleared; large RAMs normally get no reset at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_sequencer.sv
// Programmable note/LED pattern source: registered direct decode of a table entry,
// or a tempo-driven walk over entries 0..last_step, one-shot or looping.
module pattern_sequencer
  import music_box_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic             mode,
  input  logic [IN_W-1:0]  sel,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [DIV_W-1:0] tick_div,
  input  logic [IN_W-1:0]  last_step,
  output logic [OUT_W-1:0] pattern_out,
  output logic [IN_W-1:0]  step_idx,
  output logic             step_strobe,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [IN_W-1:0]  last_q, last_d;
  logic             loop_q, loop_d;
  logic [IN_W-1:0]  step_d;
  logic [OUT_W-1:0] pat_d;
  logic             strobe_d;
  logic [IN_W-1:0]  rd_addr;
  logic [OUT_W-1:0] rd_data;

  pattern_table #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch; blocking '=' is correct in comb logic.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tick_d   = tick_q;
    last_d   = last_q;
    loop_d   = loop_q;
    step_d   = step_idx;
    pat_d    = pattern_out;
    strobe_d = 1'b0;
    rd_addr  = sel;

    case (state_q)
      IDLE: begin
        if (!mode) begin
          pat_d  = rd_data;
          step_d = sel;
        end else if (start) begin
          tick_d   = tick_div;
          last_d   = last_step;
          loop_d   = loop_en;
          rd_addr  = '0;
          step_d   = '0;
          pat_d    = rd_data;
          strobe_d = 1'b1;
          div_d    = tick_div;
          state_d  = PLAY;
        end
      end

      PLAY: begin
        // Stop wins over a step load that would land in the same cycle.
        if (stop) begin
          pat_d   = '0;
          state_d = IDLE;
        end else if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else if (step_idx != last_q || loop_q) begin
          rd_addr  = (step_idx != last_q) ? step_idx + IN_W'(1) : '0;
          step_d   = rd_addr;
          pat_d    = rd_data;
          strobe_d = 1'b1;
          div_d    = tick_q;
        end else begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        pat_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      tick_q      <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      step_idx    <= '0;
      pattern_out <= '0;
      step_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      step_idx    <= step_d;
      pattern_out <= pat_d;
      step_strobe <= strobe_d;
    end
  end

  assign busy = (state_q == PLAY);
  assign done = (state_q == FINISH);

endmodule
